// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter, the ROM loader and the CPU port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEFAULT  = 14;
  localparam int DATA_W_DEFAULT  = 32;
  localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way winner pick: boot-mode priority for the loader, otherwise round-robin on ties.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic boot_mode,
  input  logic last_gnt,
  output logic grant_valid,
  output logic gnt
);

  // Loader wins outright in boot mode; on a tie the requester not granted last wins.
  always_comb begin
    grant_valid = req0 | req1;
    gnt         = 1'b0;
    if (boot_mode && req0) begin
      gnt = 1'b0;
    end else if (req0 && req1) begin
      gnt = ~last_gnt;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the ROM loader (requester 0) and the CPU (requester 1).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              boot_mode,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_en_read,
  output logic              mem_en_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  arb_state_t state;
  arb_state_t state_next;
  logic [2:0] lat_cnt;
  logic       lat_we;
  logic       gnt_q;
  logic       last_gnt;
  logic       pick_valid;
  logic       pick_gnt;

  rr_arbiter2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .boot_mode   (boot_mode),
    .last_gnt    (last_gnt),
    .grant_valid (pick_valid),
    .gnt         (pick_gnt)
  );

  // State register; reset abandons any transaction without a done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobes, done pulses and busy flag of each state.
  always_comb begin
    state_next   = state;
    busy         = 1'b1;
    mem_enable   = 1'b0;
    mem_en_read  = 1'b0;
    mem_en_write = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_enable   = 1'b1;
        mem_en_write = lat_we;
        mem_en_read  = ~lat_we;
        state_next   = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == 3'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        done0      = ~gnt_q;
        done1      = gnt_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latches the winner's request at grant, counts read latency and captures read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_cnt   <= 3'd0;
      lat_we    <= 1'b0;
      gnt_q     <= 1'b0;
      last_gnt  <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_q     <= pick_gnt;
            last_gnt  <= pick_gnt;
            lat_we    <= pick_gnt ? we1 : we0;
            mem_addr  <= pick_gnt ? addr1 : addr0;
            mem_wdata <= pick_gnt ? wdata1 : wdata0;
          end
        end
        ISSUE: begin
          if (!lat_we) begin
            lat_cnt <= LAT_LOAD;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (gnt_q) begin
              rdata1 <= mem_rdata;
            end else begin
              rdata0 <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-timeline model.
module tb_mem_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LAT = 2;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } job_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          boot_mode = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic          done0, done1, busy, mem_enable, mem_en_read, mem_en_write;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  job_t jq0[$];
  job_t jq1[$];
  bit   act0 = 1'b0, act1 = 1'b0;
  int   gap0 = 0, gap1 = 0;
  bit   rand_boot = 1'b0;

  bit            m_we, m_g, m_last;
  logic [AW-1:0] m_addr, m_maddr;
  logic [DW-1:0] m_wdata, m_mwdata, m_rd0, m_rd1;
  int            m_issue, m_done, m_free;

  bit            ring_v[8];
  logic [AW-1:0] ring_a[8];

  int            done_log[$];
  int            done_cyc_log[$];
  int            issue_log[$];
  logic [AW-1:0] addr_log[$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .boot_mode    (boot_mode),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .done0        (done0),
    .done1        (done1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .busy         (busy),
    .mem_enable   (mem_enable),
    .mem_en_read  (mem_en_read),
    .mem_en_write (mem_en_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clock = ~clock;

  // Contents of the simulated main memory: a fixed function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 14'h0100) return 32'h12345678;
    return (32'(a) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_issue = -1; m_done = -1; m_free = 0; m_last = 1'b1;
    m_we = 1'b0; m_g = 1'b0; m_addr = '0; m_wdata = '0;
    m_maddr = '0; m_mwdata = '0; m_rd0 = '0; m_rd1 = '0;
    for (int i = 0; i < 8; i++) ring_v[i] = 1'b0;
  endtask

  task automatic clearRequesters();
    jq0.delete(); jq1.delete();
    act0 = 1'b0; act1 = 1'b0; gap0 = 0; gap1 = 0;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic clearLogs();
    done_log.delete(); done_cyc_log.delete(); issue_log.delete(); addr_log.delete();
  endtask

  // Compares every output against the timeline of the transaction the model has scheduled.
  task automatic checkOutput();
    bit strobe;
    if (cyc == m_issue) begin
      m_maddr  = m_addr;
      m_mwdata = m_wdata;
    end
    if (cyc == m_done && !m_we) begin
      if (m_g) m_rd1 = mem_fn(m_addr);
      else     m_rd0 = mem_fn(m_addr);
    end
    strobe = (cyc == m_issue);
    chk("busy",         busy,         (cyc >= m_issue && cyc <= m_done));
    chk("mem_enable",   mem_enable,   strobe);
    chk("mem_en_read",  mem_en_read,  strobe && !m_we);
    chk("mem_en_write", mem_en_write, strobe && m_we);
    chk("mem_addr",     mem_addr,     m_maddr);
    chk("mem_wdata",    mem_wdata,    m_mwdata);
    chk("done0",        done0,        (cyc == m_done) && !m_g);
    chk("done1",        done1,        (cyc == m_done) && m_g);
    chk("rdata0",       rdata0,       m_rd0);
    chk("rdata1",       rdata1,       m_rd1);
    if (done0 === 1'b1) begin done_log.push_back(0); done_cyc_log.push_back(cyc); end
    if (done1 === 1'b1) begin done_log.push_back(1); done_cyc_log.push_back(cyc); end
    if (mem_enable === 1'b1) begin issue_log.push_back(cyc); addr_log.push_back(mem_addr); end
    if (cyc == m_done) begin
      if (m_g) begin act1 = 1'b0; gap1 = 0; void'(jq1.pop_front()); end
      else     begin act0 = 1'b0; gap0 = 0; void'(jq0.pop_front()); end
    end
  endtask

  // Drives requesters and memory data for this cycle, then lets the model make the IDLE decision.
  task automatic applyStimulus();
    bit g;
    if (rand_boot && ($urandom_range(0, 7) == 0)) boot_mode = ~boot_mode;
    if (!act0 && jq0.size() > 0) begin
      if (gap0 < jq0[0].gap) gap0++;
      else begin act0 = 1'b1; gap0 = 0; end
    end
    if (!act1 && jq1.size() > 0) begin
      if (gap1 < jq1[0].gap) gap1++;
      else begin act1 = 1'b1; gap1 = 0; end
    end
    if (act0) begin
      req0 = 1'b1; we0 = jq0[0].we; addr0 = jq0[0].addr; wdata0 = jq0[0].wdata;
    end else begin
      req0 = 1'b0; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
    end
    if (act1) begin
      req1 = 1'b1; we1 = jq1[0].we; addr1 = jq1[0].addr; wdata1 = jq1[0].wdata;
    end else begin
      req1 = 1'b0; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
    end
    ring_v[cyc % 8] = (mem_en_read === 1'b1);
    ring_a[cyc % 8] = mem_addr;
    if (cyc >= LAT && ring_v[(cyc - LAT) % 8]) mem_rdata = mem_fn(ring_a[(cyc - LAT) % 8]);
    else                                       mem_rdata = $urandom;
    if (reset && cyc >= m_free && (req0 || req1)) begin
      if (boot_mode && req0)  g = 1'b0;
      else if (req0 && req1)  g = ~m_last;
      else                    g = req1;
      m_g     = g;
      m_last  = g;
      m_we    = g ? we1 : we0;
      m_addr  = g ? addr1 : addr0;
      m_wdata = g ? wdata1 : wdata0;
      m_issue = cyc + 1;
      m_done  = cyc + 2 + (m_we ? 0 : LAT);
      m_free  = m_done + 1;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    checkOutput();
    applyStimulus();
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((jq0.size() > 0 || jq1.size() > 0 || cyc < m_free) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $error("[TB] FAIL drain_timeout: observed %0d cycles required below %0d", n, budget);
    end
    tick();
  endtask

  task automatic doReset();
    reset = 1'b0;
    clearRequesters();
    modelReset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic pushJob(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
    job_t j;
    j.we = we; j.addr = a; j.wdata = d; j.gap = gap;
    if (r) jq1.push_back(j);
    else   jq0.push_back(j);
  endtask

  initial begin
    modelReset();
    $display("[TB] reset state");
    doReset();

    $display("[TB] single write from loader");
    clearLogs();
    pushJob(1'b0, 1'b1, 14'h0080, 32'hDEADBEEF, 0);
    runUntilIdle(50);
    chk("wr_done_count", done_log.size(), 1);
    chk("wr_rdata0", rdata0, 32'h0);

    $display("[TB] single read from CPU");
    clearLogs();
    pushJob(1'b1, 1'b0, 14'h0100, 32'h0, 0);
    runUntilIdle(50);
    chk("rd_rdata1", rdata1, 32'h12345678);
    if (issue_log.size() == 1 && done_cyc_log.size() == 1)
      chk("rd_latency", done_cyc_log[0] - issue_log[0], 1 + LAT);
    else
      chk("rd_event_count", issue_log.size() + done_cyc_log.size(), 2);

    $display("[TB] round-robin, three reads each");
    doReset();
    clearLogs();
    for (int i = 0; i < 3; i++) begin
      pushJob(1'b0, 1'b0, AW'(14'h0200 + i), 32'h0, 0);
      pushJob(1'b1, 1'b0, AW'(14'h0300 + i), 32'h0, 0);
    end
    runUntilIdle(200);
    chk("rr_count", done_log.size(), 6);
    for (int i = 0; i < 6 && i < done_log.size(); i++) chk("rr_order", done_log[i], i % 2);

    $display("[TB] boot-mode priority, three reads each");
    clearLogs();
    boot_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pushJob(1'b0, 1'b0, AW'(14'h0400 + i), 32'h0, 0);
      pushJob(1'b1, 1'b0, AW'(14'h0500 + i), 32'h0, 0);
    end
    runUntilIdle(200);
    boot_mode = 1'b0;
    chk("boot_count", done_log.size(), 6);
    for (int i = 0; i < 6 && i < done_log.size(); i++) chk("boot_order", done_log[i], (i < 3) ? 0 : 1);

    $display("[TB] reset during WAIT");
    clearLogs();
    pushJob(1'b0, 1'b0, 14'h0123, 32'h0, 0);
    begin
      int n = 0;
      while (!(m_issue > 0 && cyc == m_issue + 1) && n < 20) begin
        tick();
        n++;
      end
      chk("wait_reached", (m_issue > 0 && cyc == m_issue + 1), 1);
    end
    #2 reset = 1'b0;
    clearRequesters();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_en_read", mem_en_read, 0);
    chk("rst_mem_en_write", mem_en_write, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    modelReset();
    tick();
    tick();
    reset = 1'b1;
    pushJob(1'b1, 1'b0, 14'h0321, 32'h0, 0);
    runUntilIdle(50);
    chk("rst_done_count", done_log.size(), 1);
    if (done_log.size() > 0) chk("rst_done_who", done_log[0], 1);

    $display("[TB] back-to-back on held req0");
    clearLogs();
    pushJob(1'b0, 1'b0, 14'h0111, 32'h0, 0);
    pushJob(1'b0, 1'b0, 14'h0222, 32'h0, 0);
    runUntilIdle(50);
    chk("b2b_issues", issue_log.size(), 2);
    if (issue_log.size() >= 2 && done_cyc_log.size() >= 1) begin
      chk("b2b_gap", issue_log[1] - done_cyc_log[0], 2);
      chk("b2b_addr", addr_log[1], 14'h0222);
    end

    $display("[TB] randomized traffic");
    rand_boot = 1'b1;
    for (int i = 0; i < 25; i++) begin
      pushJob(1'b0, 1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 3)));
      pushJob(1'b1, 1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 3)));
    end
    runUntilIdle(2000);
    rand_boot = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 14, main-memory word address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, main-memory read latency in cycles (1..7).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- boot_mode, in, 1, gives requester 0 (ROM loader) strict priority when set.
- req0 / req1, in, 1, request from requester 0 (loader) / 1 (CPU).
- we0 / we1, in, 1, 1 = write, 0 = read.
- addr0 / addr1, in, ADDR_W, word address.
- wdata0 / wdata1, in, DATA_W, write data.
- done0 / done1, out, 1, one-cycle completion pulse.
- rdata0 / rdata1, out, DATA_W, read data, valid while the matching done is high.
- busy, out, 1, arbiter not in IDLE.
- mem_enable, mem_en_read, mem_en_write, out, 1 each, memory strobes.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, valid exactly MEM_LAT cycles after the mem_en_read cycle.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, in that encoding order.
REQ-004 In IDLE with any req high, the arbiter SHALL pick a winner, latch its we/addr/wdata and a gnt index, and go to ISSUE; with no req it SHALL stay in IDLE.
REQ-005 Winner selection:
- If boot_mode=1, requester 0 SHALL win whenever req0=1.
- Otherwise a single requester SHALL win alone.
- If both request, the requester not granted last SHALL win (round-robin, last_gnt register).
REQ-006 ISSUE SHALL last exactly one cycle. It SHALL drive mem_enable=1, mem_en_write=we, mem_en_read=!we, and mem_addr/mem_wdata from the latched values.
REQ-007 After ISSUE, a write SHALL go directly to RESP. A read SHALL go to WAIT, stay there exactly MEM_LAT cycles (3-bit down-counter), and capture mem_rdata on the edge leaving WAIT.
REQ-008 RESP SHALL last one cycle, assert done of the granted requester only, drive its rdata (reads) and return to IDLE.
REQ-009 Latency from the IDLE cycle in which req is sampled (cycle t) SHALL be:
- write: mem strobes at t+1, done at t+2;
- read: mem strobes at t+1, done at t+2+MEM_LAT.
REQ-010 Requesters SHALL hold req/we/addr/wdata stable until done. A req high in the IDLE cycle following done SHALL be treated as a new request, so back-to-back accesses are legal.
REQ-011 A req that rises while the FSM is outside IDLE SHALL be ignored until IDLE and SHALL NOT be lost.
REQ-012 Outside ISSUE, all mem_* strobes SHALL be 0. mem_addr and mem_wdata SHALL hold their last value.
REQ-013 rdata0/rdata1 SHALL hold their last captured value when their done is low. Writes SHALL NOT update rdata.
REQ-014 A change of boot_mode SHALL take effect only at the next IDLE decision and SHALL NOT abort a transaction in progress.
REQ-015 busy SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-016 On reset=0, regardless of clock:
- state = IDLE;
- all strobes, done0/1 and busy = 0;
- mem_addr, mem_wdata, rdata0/1 = 0;
- latency counter = 0;
- last_gnt = 1, so requester 0 wins the first tie.
REQ-017 A reset asserted mid-transaction SHALL abandon it with no done pulse. The first request after reset release SHALL be arbitrated afresh from IDLE.

Structure
REQ-018 A shared package SHALL hold the state encoding, ADDR_W/DATA_W defaults and the MEM_LAT default, for use by the loader, CPU and this block.
REQ-019 The two-way round-robin/priority pick SHALL be a combinational sub-module named rr_arbiter2. The FSM, latency counter and data registers SHALL stay in mem_arbiter.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- req0 write, addr=0x0080, wdata=0xDEADBEEF -> mem_enable=mem_en_write=1 at t+1 with mem_addr=0x0080; done0 at t+2; rdata0 unchanged.
- req1 read addr=0x0100, memory returns 0x12345678, MEM_LAT=2 -> mem_en_read at t+1, done1 with rdata1=0x12345678 at t+4, busy 1 for t+1..t+4.
- req0 and req1 both high, boot_mode=0, three back-to-back reads each -> grants alternate 0,1,0,1,0,1, starting with 0 after reset.
- Same as above with boot_mode=1 -> all three req0 accesses complete before the first done1.
- Reset pulled low during WAIT -> outputs 0 immediately, no done; a new read after release completes with correct latency.
- Requester keeps req0 high across done with a new addr -> next ISSUE exactly 2 cycles after the previous done, carrying the new address.
